// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: result-select codes, load funct3 codes
// and the layout of the WB pipeline register.
package wb_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] load_data;
  } wb_reg_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load extraction: picks the byte/halfword addressed by the low address
// bits out of an aligned word and sign- or zero-extends it to 32 bits.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    case (offset)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    // Halfword selection deliberately ignores offset[0]; misalignment is not trapped here.
    half_s = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   value = 32'(byte_s);
      F3_LBU:  value = {24'd0, byte_s};
      F3_LH:   value = 32'(half_s);
      F3_LHU:  value = {16'd0, half_s};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one pipeline register after MEM plus result selection for the
// register file. Define WB_INSTRET_EN to add the retired-instruction counter/port.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic                 mem_reg_write,
  input  logic [4:0]           mem_rd,
  input  logic [1:0]           mem_wb_sel,
  input  logic [2:0]           mem_funct3,
  input  logic [31:0]          mem_alu_result,
  input  logic [31:0]          mem_pc_plus4,
  input  logic [31:0]          mem_load_data,
  input  logic                 stall,
  input  logic                 flush,
`ifdef WB_INSTRET_EN
  output logic [INSTRET_W-1:0] instret,
`endif
  output logic                 write_ena,
  output logic [4:0]           rd,
  output logic [31:0]          write_data,
  output logic                 wb_valid
);

  wb_reg_t     wb_q, wb_d;
  logic [31:0] load_val;

  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d.valid = 1'b0;
    end else if (!stall) begin
      wb_d.valid      = mem_valid;
      wb_d.reg_write  = mem_reg_write;
      wb_d.rd         = mem_rd;
      wb_d.wb_sel     = mem_wb_sel;
      wb_d.funct3     = mem_funct3;
      wb_d.alu_result = mem_alu_result;
      wb_d.pc_plus4   = mem_pc_plus4;
      wb_d.load_data  = mem_load_data;
    end
  end

  // MEM -> WB boundary
  always_ff @(posedge clk) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  load_align u_load_align (
    .word   (wb_q.load_data),
    .offset (wb_q.alu_result[1:0]),
    .funct3 (wb_q.funct3),
    .value  (load_val)
  );

  always_comb begin
    case (wb_q.wb_sel)
      WB_SEL_ALU:  write_data = wb_q.alu_result;
      WB_SEL_LOAD: write_data = load_val;
      WB_SEL_PC4:  write_data = wb_q.pc_plus4;
      default:     write_data = 32'd0;
    endcase
  end

  assign write_ena = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0);
  assign rd        = wb_q.rd;
  assign wb_valid  = wb_q.valid;

`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q, instret_d;

  assign instret_d = (mem_valid & ~stall & ~flush) ? instret_q + 1'b1 : instret_q;

  always_ff @(posedge clk) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a behavioural reference model.
module tb_wb_stage;

  localparam int IW = 8;

  logic        clk = 1'b0;
  logic        reset, mem_valid, mem_reg_write, stall, flush;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_pc_plus4, mem_load_data;
  logic        write_ena, wb_valid;
  logic [4:0]  rd;
  logic [31:0] write_data;
`ifdef WB_INSTRET_EN
  logic [IW-1:0] instret;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit          m_valid, m_rw;
  int          m_rd, m_sel, m_f3;
  logic [31:0] m_alu, m_pc4, m_ld;
  int          m_cnt;

  wb_stage #(.INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .mem_load_data(mem_load_data), .stall(stall), .flush(flush),
`ifdef WB_INSTRET_EN
    .instret(instret),
`endif
    .write_ena(write_ena), .rd(rd), .write_data(write_data), .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(logic [31:0] w, int off, int f3);
    int b, h;
    b = int'((w >> (8 * off)) & 32'hFF);
    h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
    case (f3)
      0:       return (b >= 128) ? 32'(b - 256) : 32'(b);
      4:       return 32'(b);
      1:       return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      5:       return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_data();
    case (m_sel)
      0:       return m_alu;
      1:       return ref_load(m_ld, int'(m_alu % 4), m_f3);
      2:       return m_pc4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_we();
    return m_valid && m_rw && (m_rd != 0);
  endfunction

  task automatic drive(bit v, bit rw, int r, int sel, int f3, logic [31:0] alu,
                       logic [31:0] pc4, logic [31:0] ld, bit st, bit fl, bit rst);
    mem_valid = v; mem_reg_write = rw; mem_rd = 5'(r); mem_wb_sel = 2'(sel);
    mem_funct3 = 3'(f3); mem_alu_result = alu; mem_pc_plus4 = pc4; mem_load_data = ld;
    stall = st; flush = fl; reset = rst;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
      m_alu = 0; m_pc4 = 0; m_ld = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (!stall) begin
      m_valid = mem_valid; m_rw = mem_reg_write; m_rd = int'(mem_rd);
      m_sel = int'(mem_wb_sel); m_f3 = int'(mem_funct3);
      m_alu = mem_alu_result; m_pc4 = mem_pc_plus4; m_ld = mem_load_data;
      if (mem_valid) m_cnt = (m_cnt + 1) % (1 << IW);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 9, 0, 0, 32'hDEADBEEF, 32'h4, 32'h1, 1, 1, 1);
    tick(); tick();
    n_cmp++;
    if ({write_ena, wb_valid, rd, write_data} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_outputs got we=%b v=%b rd=%0d data=%h want all 0",
               write_ena, wb_valid, rd, write_data);
    end
`ifdef WB_INSTRET_EN
    n_cmp++;
    if (instret !== '0) begin n_err++; $display("FAIL reset_instret got %0d want 0", instret); end
`endif
  endtask

  task automatic test_load_sweep();
    logic [31:0] lb [4]  = '{32'hFFFFFFBB, 32'hFFFFFFAA, 32'hFFFFFF99, 32'hFFFFFF88};
    logic [31:0] lbu [4] = '{32'hBB, 32'hAA, 32'h99, 32'h88};
    for (int off = 0; off < 4; off++) begin
      drive(1, 1, 3, 1, 0, 32'h1000 + 32'(off), 0, 32'h8899AABB, 0, 0, 0);
      tick();
      n_cmp++;
      if (write_data !== lb[off]) begin
        n_err++; $display("FAIL lb_off%0d got %h want %h", off, write_data, lb[off]);
      end
      drive(1, 1, 3, 1, 4, 32'h1000 + 32'(off), 0, 32'h8899AABB, 0, 0, 0);
      tick();
      n_cmp++;
      if (write_data !== lbu[off]) begin
        n_err++; $display("FAIL lbu_off%0d got %h want %h", off, write_data, lbu[off]);
      end
    end
    drive(1, 1, 3, 1, 1, 32'h1002, 0, 32'h8899AABB, 0, 0, 0);
    tick();
    n_cmp++;
    if (write_data !== 32'hFFFF8899) begin
      n_err++; $display("FAIL lh_off2 got %h want ffff8899", write_data);
    end
    drive(1, 1, 3, 1, 5, 32'h1000, 0, 32'h8899AABB, 0, 0, 0);
    tick();
    n_cmp++;
    if (write_data !== 32'h0000AABB) begin
      n_err++; $display("FAIL lhu_off0 got %h want 0000aabb", write_data);
    end
    drive(1, 1, 3, 1, 1, 32'h1003, 0, 32'h8899AABB, 0, 0, 0);
    tick();
    n_cmp++;
    if (write_data !== 32'hFFFF8899) begin
      n_err++; $display("FAIL lh_off3 got %h want ffff8899", write_data);
    end
    drive(1, 1, 3, 1, 7, 32'h1001, 0, 32'h8899AABB, 0, 0, 0);
    tick();
    n_cmp++;
    if (write_data !== 32'h8899AABB) begin
      n_err++; $display("FAIL f3_other got %h want 8899aabb", write_data);
    end
  endtask

  task automatic test_result_mux();
    drive(1, 1, 4, 0, 0, 32'h12345678, 32'h104, 32'hFFFFFFFF, 0, 0, 0);
    tick();
    n_cmp++;
    if (write_data !== 32'h12345678) begin
      n_err++; $display("FAIL mux_alu got %h want 12345678", write_data);
    end
    drive(1, 1, 4, 2, 0, 32'h12345678, 32'h104, 32'hFFFFFFFF, 0, 0, 0);
    tick();
    n_cmp++;
    if (write_data !== 32'h00000104) begin
      n_err++; $display("FAIL mux_pc4 got %h want 00000104", write_data);
    end
    drive(1, 1, 4, 3, 0, 32'h12345678, 32'h104, 32'hFFFFFFFF, 0, 0, 0);
    tick();
    n_cmp++;
    if (write_data !== 32'd0) begin
      n_err++; $display("FAIL mux_rsvd got %h want 00000000", write_data);
    end
  endtask

  task automatic test_x0_guard();
    drive(1, 1, 0, 0, 0, 32'hAA, 0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if (write_ena !== 1'b0) begin n_err++; $display("FAIL x0_we got %b want 0", write_ena); end
    drive(1, 1, 5, 0, 0, 32'hAA, 0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if (write_ena !== 1'b1 || rd !== 5'd5) begin
      n_err++; $display("FAIL rd5_we got we=%b rd=%0d want we=1 rd=5", write_ena, rd);
    end
    drive(1, 0, 5, 0, 0, 32'hAA, 0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if (write_ena !== 1'b0) begin n_err++; $display("FAIL nowrite_we got %b want 0", write_ena); end
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 7, 0, 0, 32'h00000055, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 12, 2, 0, 32'h99, 32'h77, 0, 1, 0, 0);
      tick();
      n_cmp++;
      if (write_ena !== 1'b1 || rd !== 5'd7 || write_data !== 32'h55 || wb_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold%0d got we=%b rd=%0d data=%h v=%b want we=1 rd=7 data=00000055 v=1",
                 i, write_ena, rd, write_data, wb_valid);
      end
    end
    drive(1, 1, 12, 2, 0, 32'h99, 32'h77, 0, 1, 1, 0);
    tick();
    n_cmp++;
    if (wb_valid !== 1'b0 || write_ena !== 1'b0) begin
      n_err++; $display("FAIL flush_over_stall got v=%b we=%b want 0 0", wb_valid, write_ena);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1, 1, 9, 0, 0, 32'hCAFE0000, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 9, 0, 0, 32'hCAFE0000, 0, 0, 1, 0, 1);
    tick();
    n_cmp++;
    if ({write_ena, wb_valid, rd, write_data} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_mid got we=%b v=%b rd=%0d data=%h want all 0",
               write_ena, wb_valid, rd, write_data);
    end
`ifdef WB_INSTRET_EN
    n_cmp++;
    if (instret !== '0) begin n_err++; $display("FAIL reset_mid_instret got %0d want 0", instret); end
`endif
  endtask

`ifdef WB_INSTRET_EN
  task automatic test_counter();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1 + i, 0, 0, 32'(i), 0, 0, 0, 0, 0); tick();
      if (i == 3) begin drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0); tick(); tick(); end
      if (i == 6) begin drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0); tick(); end
      if (i == 8) begin drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
    end
    n_cmp++;
    if (instret !== IW'(10)) begin n_err++; $display("FAIL instret_10 got %0d want 10", instret); end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 10; i < (1 << IW) - 1; i++) tick();
    n_cmp++;
    if (instret !== {IW{1'b1}}) begin
      n_err++; $display("FAIL instret_max got %0d want %0d", instret, (1 << IW) - 1);
    end
    tick();
    n_cmp++;
    if (instret !== '0) begin n_err++; $display("FAIL instret_wrap got %0d want 0", instret); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 24) == 0);
      tick();
      n_cmp++;
      if (write_ena !== ref_we() || wb_valid !== m_valid || rd !== 5'(m_rd) ||
          write_data !== ref_data()) begin
        n_err++;
        $display("FAIL rand%0d got we=%b v=%b rd=%0d data=%h want we=%b v=%b rd=%0d data=%h",
                 i, write_ena, wb_valid, rd, write_data, ref_we(), m_valid, m_rd, ref_data());
      end
`ifdef WB_INSTRET_EN
      n_cmp++;
      if (instret !== IW'(m_cnt)) begin
        n_err++; $display("FAIL rand%0d_instret got %0d want %0d", i, instret, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    m_cnt = 0;
    test_reset();
    test_load_sweep();
    test_result_mux();
    test_x0_guard();
    test_stall_flush();
    test_reset_midstream();
`ifdef WB_INSTRET_EN
    test_counter();
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
